// File: rtl/video_timing_output_pkg.sv
// Shared types and default System86 raster constants for the video timing/output block.
package video_timing_output_pkg;

  localparam int CNT_W = 9;

  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_H_ACTIVE = 288;
  localparam int DEF_HS_START = 304;
  localparam int DEF_HS_WIDTH = 32;
  localparam int DEF_V_TOTAL  = 264;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_WIDTH = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } raw_t;

  localparam int RAW_W = $bits(raw_t);

  function automatic logic in_window(cnt_t c, int start, int width);
    return (int'(c) >= start) && (int'(c) < start + width);
  endfunction

endpackage

// File: rtl/video_timing_output_if.sv
// Video path bundle: CLUT colour in, raster counters and DAC/monitor signals out.
interface video_timing_output_if;
  import video_timing_output_pkg::*;

  logic [3:0] R, G, B;
  cnt_t       HCNT, VCNT;
  logic [3:0] R_OUT, G_OUT, B_OUT;
  logic       BLANK_N, HSYNC_N, VSYNC_N, VBLANK_IRQ;

  modport master (
    input  R, G, B,
    output HCNT, VCNT, R_OUT, G_OUT, B_OUT, BLANK_N, HSYNC_N, VSYNC_N, VBLANK_IRQ
  );

  modport slave (
    output R, G, B,
    input  HCNT, VCNT, R_OUT, G_OUT, B_OUT, BLANK_N, HSYNC_N, VSYNC_N, VBLANK_IRQ
  );

endinterface

// File: rtl/video_delay_line.sv
// N-stage, W-bit shift register with async active-low clear (N >= 1).
module video_delay_line #(
  parameter int N = 1,
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [N-1:0][W-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/video_timing_output.sv
// Raster counters, sync/blank generation and the final blank-gated RGB register.
module video_timing_output
  import video_timing_output_pkg::*;
#(
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int HS_START   = DEF_HS_START,
  parameter int HS_WIDTH   = DEF_HS_WIDTH,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int VS_START   = DEF_VS_START,
  parameter int VS_WIDTH   = DEF_VS_WIDTH,
  parameter int PIPE_DELAY = 2
) (
  input  logic                  CLK_6M,
  input  logic                  CLR,
  video_timing_output_if.master vid
);

  cnt_t       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       h_wrap, v_wrap, irq_d, irq_q;
  raw_t       raw_now, raw_dly;
  logic [11:0] rgb_q;
  logic       blank_n_q, hsync_n_q, vsync_n_q;

  always_comb begin
    h_wrap = (hcnt_q == cnt_t'(H_TOTAL - 1));
    v_wrap = (vcnt_q == cnt_t'(V_TOTAL - 1));
    hcnt_d = h_wrap ? '0 : hcnt_q + cnt_t'(1);
    vcnt_d = vcnt_q;
    if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + cnt_t'(1);
    // Fires on the edge that lands on (0, V_ACTIVE), so the pulse covers that clock.
    irq_d  = h_wrap && (vcnt_d == cnt_t'(V_ACTIVE));
  end

  always_comb begin
    raw_now        = '0;
    raw_now.active = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    raw_now.hs     = in_window(hcnt_q, HS_START, HS_WIDTH);
    raw_now.vs     = in_window(vcnt_q, VS_START, VS_WIDTH);
  end

  // The output register supplies the final clock of latency; the line covers the rest.
  generate
    if (PIPE_DELAY > 1) begin : g_dly
      video_delay_line #(.N(PIPE_DELAY - 1), .W(RAW_W)) u_dly (
        .clk_i   (CLK_6M),
        .rst_n_i (CLR),
        .d_i     (raw_now),
        .q_o     (raw_dly)
      );
    end else begin : g_nodly
      assign raw_dly = raw_now;
    end
  endgenerate

  always_ff @(posedge CLK_6M or negedge CLR) begin
    if (!CLR) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      irq_q     <= 1'b0;
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      irq_q     <= irq_d;
      rgb_q     <= raw_dly.active ? {vid.R, vid.G, vid.B} : 12'h000;
      blank_n_q <= raw_dly.active;
      hsync_n_q <= ~raw_dly.hs;
      vsync_n_q <= ~raw_dly.vs;
    end
  end

  assign vid.HCNT       = hcnt_q;
  assign vid.VCNT       = vcnt_q;
  assign vid.R_OUT      = rgb_q[11:8];
  assign vid.G_OUT      = rgb_q[7:4];
  assign vid.B_OUT      = rgb_q[3:0];
  assign vid.BLANK_N    = blank_n_q;
  assign vid.HSYNC_N    = hsync_n_q;
  assign vid.VSYNC_N    = vsync_n_q;
  assign vid.VBLANK_IRQ = irq_q;

endmodule

// File: tb/tb_video_timing_output.sv
// Bench: default-timing instance plus a tiny-raster instance, checked against a queue-based raster model.
module tb_video_timing_output;
  import video_timing_output_pkg::*;

  logic clk = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0;
  always #5 clk = ~clk;

  video_timing_output_if ia ();
  video_timing_output_if ib ();

  video_timing_output u_a (.CLK_6M(clk), .CLR(clr_a), .vid(ia));

  video_timing_output #(
    .H_TOTAL(8), .H_ACTIVE(4), .HS_START(5), .HS_WIDTH(2),
    .V_TOTAL(6), .V_ACTIVE(3), .VS_START(4), .VS_WIDTH(1), .PIPE_DELAY(1)
  ) u_b (.CLK_6M(clk), .CLR(clr_b), .vid(ib));

  typedef struct packed {
    logic [8:0]  h;
    logic [8:0]  v;
    logic [11:0] rgb;
    logic        blank_n, hsync_n, vsync_n, irq;
  } obs_t;

  typedef struct {
    int t; int h; int v; logic [11:0] rgb; logic bn; logic hsn;
  } vec_t;

  localparam obs_t RST_OBS = '{h: 9'd0, v: 9'd0, rgb: 12'h000, blank_n: 1'b0,
                               hsync_n: 1'b1, vsync_n: 1'b1, irq: 1'b0};

  int checks = 0, failures = 0;
  int sel, t;
  int p_ht, p_ha, p_hss, p_hsw, p_vt, p_va, p_vss, p_vsw, p_pd;
  logic fff_mode;
  logic [11:0] prev_rgb;
  raw_t q[$];
  int hs_falls[$], hs_rises[$], vs_falls[$], vs_rises[$];
  int irq_cnt, blank_cnt;
  logic prev_hs, prev_vs;
  vec_t tbl[14];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic obs_t get_obs(int s);
    obs_t o;
    if (s == 0) o = '{ia.HCNT, ia.VCNT, {ia.R_OUT, ia.G_OUT, ia.B_OUT}, ia.BLANK_N, ia.HSYNC_N, ia.VSYNC_N, ia.VBLANK_IRQ};
    else        o = '{ib.HCNT, ib.VCNT, {ib.R_OUT, ib.G_OUT, ib.B_OUT}, ib.BLANK_N, ib.HSYNC_N, ib.VSYNC_N, ib.VBLANK_IRQ};
    return o;
  endfunction

  task automatic drive_rgb(logic [11:0] c);
    if (sel == 0) {ia.R, ia.G, ia.B} = c;
    else          {ib.R, ib.G, ib.B} = c;
  endtask

  // Called once per clock interval t (t edges since release), away from the edge.
  task automatic sample_check();
    int h, v;
    raw_t r, e;
    obs_t got, exp;
    logic [11:0] nrgb;
    h = t % p_ht;
    v = (t / p_ht) % p_vt;
    r.active = (h < p_ha) && (v < p_va);
    r.hs     = (h >= p_hss) && (h < p_hss + p_hsw);
    r.vs     = (v >= p_vss) && (v < p_vss + p_vsw);
    q.push_back(r);
    e = q.pop_front();
    exp.h = 9'(h);
    exp.v = 9'(v);
    exp.rgb = e.active ? prev_rgb : 12'h000;
    exp.blank_n = e.active;
    exp.hsync_n = ~e.hs;
    exp.vsync_n = ~e.vs;
    exp.irq = (t > 0) && (h == 0) && (v == p_va);
    got = get_obs(sel);
    chk($sformatf("dut%0d_t%0d", sel, t), 64'(got), 64'(exp));
    if (prev_hs && !got.hsync_n) hs_falls.push_back(t);
    if (!prev_hs && got.hsync_n) hs_rises.push_back(t);
    if (prev_vs && !got.vsync_n) vs_falls.push_back(t);
    if (!prev_vs && got.vsync_n) vs_rises.push_back(t);
    prev_hs = got.hsync_n;
    prev_vs = got.vsync_n;
    if (got.irq) irq_cnt++;
    if (t < p_ht && got.blank_n) blank_cnt++;
    nrgb = fff_mode ? 12'hFFF : 12'($urandom);
    drive_rgb(nrgb);
    prev_rgb = nrgb;
    t++;
  endtask

  task automatic step();
    @(negedge clk);
    sample_check();
  endtask

  task automatic release_run();
    raw_t idle;
    idle = '0;
    @(negedge clk);
    if (sel == 0) clr_a = 1'b1; else clr_b = 1'b1;
    q.delete();
    for (int i = 0; i < p_pd; i++) q.push_back(idle);
    hs_falls.delete(); hs_rises.delete(); vs_falls.delete(); vs_rises.delete();
    prev_hs = 1'b1; prev_vs = 1'b1;
    irq_cnt = 0; blank_cnt = 0;
    t = 0;
    prev_rgb = 12'h000;
    sample_check();
  endtask

  initial begin
    obs_t o;
    tbl[0]  = '{0,   0,   0, 12'h000, 1'b0, 1'b1};
    tbl[1]  = '{1,   1,   0, 12'h000, 1'b0, 1'b1};
    tbl[2]  = '{2,   2,   0, 12'hFFF, 1'b1, 1'b1};
    tbl[3]  = '{289, 289, 0, 12'hFFF, 1'b1, 1'b1};
    tbl[4]  = '{290, 290, 0, 12'h000, 1'b0, 1'b1};
    tbl[5]  = '{305, 305, 0, 12'h000, 1'b0, 1'b1};
    tbl[6]  = '{306, 306, 0, 12'h000, 1'b0, 1'b0};
    tbl[7]  = '{337, 337, 0, 12'h000, 1'b0, 1'b0};
    tbl[8]  = '{338, 338, 0, 12'h000, 1'b0, 1'b1};
    tbl[9]  = '{383, 383, 0, 12'h000, 1'b0, 1'b1};
    tbl[10] = '{384, 0,   1, 12'h000, 1'b0, 1'b1};
    tbl[11] = '{386, 2,   1, 12'hFFF, 1'b1, 1'b1};
    tbl[12] = '{767, 383, 1, 12'h000, 1'b0, 1'b1};
    tbl[13] = '{768, 0,   2, 12'h000, 1'b0, 1'b1};

    // Reset with full-white colour presented.
    {ia.R, ia.G, ia.B} = 12'hFFF;
    {ib.R, ib.G, ib.B} = 12'hFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 64'(get_obs(0)), 64'(RST_OBS));
    chk("reset_b", 64'(get_obs(1)), 64'(RST_OBS));

    // Default raster, constant white input.
    sel = 0; fff_mode = 1'b1;
    p_ht = 384; p_ha = 288; p_hss = 304; p_hsw = 32;
    p_vt = 264; p_va = 224; p_vss = 240; p_vsw = 3; p_pd = 2;
    release_run();
    for (int i = 0; i < 14; i++) begin
      while (t <= tbl[i].t) step();
      o = get_obs(0);
      chk($sformatf("vec%0d", i),
          {int'(o.h), int'(o.v), 20'(o.rgb), o.blank_n, o.hsync_n},
          {tbl[i].h, tbl[i].v, 20'(tbl[i].rgb), tbl[i].bn, tbl[i].hsn});
    end
    chk("blank_per_line", 64'(blank_cnt), 64'd288);
    chk("hs_first_fall", 64'(hs_falls.size() > 0 ? hs_falls[0] : -1), 64'd306);
    chk("hs_period", 64'(hs_falls.size() > 1 ? hs_falls[1] - hs_falls[0] : -1), 64'd384);
    chk("hs_width", 64'(hs_rises.size() > 0 && hs_falls.size() > 0 ? hs_rises[0] - hs_falls[0] : -1), 64'd32);

    // Random colour, run to (HCNT,VCNT) = (150,100), then reset mid-frame.
    fff_mode = 1'b0;
    while (t <= 100 * 384 + 150) step();
    o = get_obs(0);
    chk("pre_reset_pos", {int'(o.h), int'(o.v)}, {32'd150, 32'd100});
    #1 clr_a = 1'b0;
    #1 chk("midframe_reset_now", 64'(get_obs(0)), 64'(RST_OBS));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midframe_reset_held", 64'(get_obs(0)), 64'(RST_OBS));
    release_run();
    while (t < 700) step();
    chk("hs_fall_after_reset", 64'(hs_falls.size() > 0 ? hs_falls[0] : -1), 64'd306);

    // Tiny raster: every position over three frames.
    sel = 1;
    p_ht = 8; p_ha = 4; p_hss = 5; p_hsw = 2;
    p_vt = 6; p_va = 3; p_vss = 4; p_vsw = 1; p_pd = 1;
    release_run();
    while (t < 3 * 48 + 10) step();
    chk("b_irq_count", 64'(irq_cnt), 64'd3);
    chk("b_vs_first_fall", 64'(vs_falls.size() > 0 ? vs_falls[0] : -1), 64'd33);
    chk("b_vs_period", 64'(vs_falls.size() > 1 ? vs_falls[1] - vs_falls[0] : -1), 64'd48);
    chk("b_vs_width", 64'(vs_rises.size() > 0 && vs_falls.size() > 0 ? vs_rises[0] - vs_falls[0] : -1), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
